// File: rtl/md_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_param
// Brief    : E-stage multiply/divide unit holding HI/LO, with configurable
//            mult/div latency and exception squash. Define MD_MADD_EN to
//            enable madd/maddu/msub/msubu.
// Revision : 1.0
// ============================================================================
module md_unit_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] hl_data,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;
`ifdef MD_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd9;
    localparam logic [3:0] c_OP_MADDU = 4'd10;
    localparam logic [3:0] c_OP_MSUB  = 4'd11;
    localparam logic [3:0] c_OP_MSUBU = 4'd12;
`endif

    localparam logic [CNT_W-1:0] c_MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] c_MIN      = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_pend;

    logic               w_mult_class;
    logic               w_div_class;
    logic               w_start;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [WIDTH-1:0]   w_q_s;
    logic [WIDTH-1:0]   w_r_s;
    logic [WIDTH-1:0]   w_q_u;
    logic [WIDTH-1:0]   w_r_u;
    logic [2*WIDTH-1:0] w_result;

    // Operands are widened to 2*WIDTH so the product is exact modulo 2^(2*WIDTH).
    assign w_prod_s = $signed({{WIDTH{data1[WIDTH-1]}}, data1})
                    * $signed({{WIDTH{data2[WIDTH-1]}}, data2});
    assign w_prod_u = {{WIDTH{1'b0}}, data1} * {{WIDTH{1'b0}}, data2};

    assign w_div_zero = (data2 == '0);
    assign w_div_ovf  = (data1 == c_MIN) && (data2 == {WIDTH{1'b1}});
    assign w_q_s      = $signed(data1) / $signed(data2);
    assign w_r_s      = $signed(data1) % $signed(data2);
    assign w_q_u      = data1 / data2;
    assign w_r_u      = data1 % data2;

    always_comb begin
        w_mult_class = (op == c_OP_MULT) || (op == c_OP_MULTU);
`ifdef MD_MADD_EN
        if ((op == c_OP_MADD) || (op == c_OP_MADDU) ||
            (op == c_OP_MSUB) || (op == c_OP_MSUBU)) begin
            w_mult_class = 1'b1;
        end
`endif
        w_div_class = (op == c_OP_DIV) || (op == c_OP_DIVU);
    end

    assign w_start = (w_mult_class || w_div_class) && !r_busy && !req;

    // Results are packed {HI, LO}; divide special cases bypass the divider.
    always_comb begin
        w_result = '0;
        case (op)
            c_OP_MULT:  w_result = w_prod_s;
            c_OP_MULTU: w_result = w_prod_u;
            c_OP_DIV: begin
                if (w_div_zero)     w_result = {data1, {WIDTH{1'b1}}};
                else if (w_div_ovf) w_result = {{WIDTH{1'b0}}, c_MIN};
                else                w_result = {w_r_s, w_q_s};
            end
            c_OP_DIVU: begin
                if (w_div_zero) w_result = {data1, {WIDTH{1'b1}}};
                else            w_result = {w_r_u, w_q_u};
            end
`ifdef MD_MADD_EN
            c_OP_MADD:  w_result = {r_hi, r_lo} + w_prod_s;
            c_OP_MADDU: w_result = {r_hi, r_lo} + w_prod_u;
            c_OP_MSUB:  w_result = {r_hi, r_lo} - w_prod_s;
            c_OP_MSUBU: w_result = {r_hi, r_lo} - w_prod_u;
`endif
            default:    w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_pend <= '0;
        end else if (r_busy) begin
            // The in-flight op ignores req: it is older than the faulting one.
            r_cnt <= r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
                r_hi   <= r_pend[2*WIDTH-1:WIDTH];
                r_lo   <= r_pend[WIDTH-1:0];
                r_busy <= 1'b0;
            end
        end else if (!req) begin
            if (w_start) begin
                r_pend <= w_result;
                r_cnt  <= w_mult_class ? c_MULT_CNT : c_DIV_CNT;
                r_busy <= 1'b1;
            end else if (op == c_OP_MTHI) begin
                r_hi <= data1;
            end else if (op == c_OP_MTLO) begin
                r_lo <= data1;
            end
        end
    end

    always_comb begin
        hl_data = '0;
        if (op == c_OP_MFHI)      hl_data = r_hi;
        else if (op == c_OP_MFLO) hl_data = r_lo;
    end

    assign md_stall = r_busy || ((w_mult_class || w_div_class) && !req);
    assign busy     = r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire
